mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Memory access controller for the LC-3 datapath. It owns the MAR and MDR registers and turns a microcode memory request (MIO_EN, R.W) into a req/ack transaction on the external memory port. It returns the LC-3 ready bit R to the microsequencer. It sits on the far side of the MAR input path: the address placed on the bus is loaded into MAR here and driven to memory.

## Interface
- ADDR_W, 16, address width (MAR, o_MemAddr)
- DATA_W, 16, data width (bus, MDR, memory data)
- TIMEOUT, 255, max BUSY cycles without ack before abort; 0 disables the timeout
- i_Clk  in  1  system clock, rising edge
- i_Reset  in  1  reset: one clock; reset is asynchronous and active-high
- i_LdMar  in  1  load MAR from i_Bus
- i_LdMdr  in  1  load MDR (source chosen by i_MioEn)
- i_MioEn  in  1  memory access enable from control store
- i_RW  in  1  1 = write, 0 = read
- i_Bus  in  DATA_W  datapath bus
- o_Mar  out  ADDR_W  MAR register value
- o_Mdr  out  DATA_W  MDR register value (bus gating external)
- o_Ready  out  1  LC-3 R bit, one-cycle pulse at access completion
- o_MemReq  out  1  memory request, held until ack/timeout
- o_MemWe  out  1  write enable, valid while o_MemReq=1
- o_MemAddr  out  ADDR_W  request address, stable during request
- o_MemWData  out  DATA_W  write data, stable during request
- i_MemRData  in  DATA_W  read data, valid with i_MemAck
- i_MemAck  in  1  access complete; ignored when o_MemReq=0
- o_MemErr  out  1  sticky timeout flag

## Operation
- The FSM has three states: IDLE, BUSY, DONE.
- IDLE:
  - If i_MioEn=1, latch MAR into o_MemAddr, MDR into o_MemWData, and i_RW into o_MemWe, then go to BUSY.
  - The latched values are the registered ones, so an i_LdMar or i_LdMdr in the same cycle is not seen by this access.
- BUSY:
  - o_MemReq=1 and the cycle counter increments.
  - If i_MemAck=1, capture i_MemRData into the read buffer and go to DONE.
  - If the counter reaches TIMEOUT (TIMEOUT≠0) with no ack, set o_MemErr, force the read buffer to 0x0000, drop o_MemReq, and go to DONE.
  - An ack arriving in the same cycle as the timeout wins: o_MemErr is not set.
- DONE:
  - o_Ready=1.
  - If i_LdMdr=1, i_MioEn=1 and o_MemWe=0, load MDR from the read buffer.
  - Always return to IDLE. If i_MioEn is still high there, a new access starts, so back-to-back accesses are legal.
- MAR: loads i_Bus on i_LdMar in any state. The in-flight o_MemAddr is unaffected.
- MDR:
  - With i_LdMdr=1 and i_MioEn=0, MDR loads i_Bus in any state.
  - With i_LdMdr=1 and i_MioEn=1 outside DONE, the load is ignored.
- o_MemErr: stays high until reset.
- Counter width: clog2(TIMEOUT+1). It clears on entry to BUSY.

## Timing
- Reset values: all outputs, MAR, MDR, read buffer and counter are 0; state is IDLE.
- Reset mid-access drops o_MemReq asynchronously; a later ack is ignored.
- All outputs are registered; no combinational path from inputs to outputs.
- Read latency, with i_MioEn sampled in cycle 0:
  - o_MemReq rises in cycle 1.
  - Ack is sampled in cycle k≥1.
  - o_MemReq falls and o_Ready=1 in cycle k+1.
  - MDR takes the new value at the end of cycle k+1.
- Zero-wait memory (ack in cycle 1): o_Ready in cycle 2, so 3 cycles from request to IDLE.
- Timeout: o_Ready in cycle TIMEOUT+1, and o_MemErr rises in that same cycle.
- The microsequencer holds i_MioEn, i_RW and i_LdMdr until it sees o_Ready.

## Test plan
- Read, 0-wait: reset, LdMar with Bus=0x3000; MioEn=1, RW=0, LdMdr=1; memory acks in cycle 1 with 0xBEEF.
  - Expect o_MemAddr=0x3000, o_MemWe=0, o_Ready pulse in cycle 2, o_Mdr=0xBEEF in cycle 3.
- Write, 3-wait: MAR=0x4001, MDR=0x1234 (loaded with MioEn=0); MioEn=1, RW=1; ack in cycle 4.
  - Expect o_MemWe=1, o_MemWData=0x1234 held for cycles 1-4, o_Ready in cycle 5, MDR unchanged.
- Address stability: during BUSY, pulse LdMar with 0xFFFF.
  - Expect o_MemAddr still 0x3000 until completion and o_Mar=0xFFFF.
- Timeout: TIMEOUT=4, never ack.
  - Expect o_MemReq high for cycles 1-4, o_Ready and o_MemErr high in cycle 5, MDR=0x0000 on read.
  - o_MemErr stays high through later good accesses.
- Back-to-back: hold MioEn high across two reads (acks 0x0001, then 0x0002).
  - Expect two o_Ready pulses 3 cycles apart and MDR sequence 0x0001, 0x0002.
- Reset mid-BUSY: assert i_Reset between clock edges during a request.
  - Expect o_MemReq=0 immediately and all outputs 0.
  - A later ack produces no o_Ready and no MDR change.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: LC-3 memory access controller.
// Owns MAR/MDR and converts a microcode memory request (MIO_EN, R.W) into a
// req/ack transaction on the external memory port, returning the R bit.
module mem_ctrl #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              i_Clk,
    input  logic              i_Reset,
    input  logic              i_LdMar,
    input  logic              i_LdMdr,
    input  logic              i_MioEn,
    input  logic              i_RW,
    input  logic [DATA_W-1:0] i_Bus,
    output logic [ADDR_W-1:0] o_Mar,
    output logic [DATA_W-1:0] o_Mdr,
    output logic              o_Ready,
    output logic              o_MemReq,
    output logic              o_MemWe,
    output logic [ADDR_W-1:0] o_MemAddr,
    output logic [DATA_W-1:0] o_MemWData,
    input  logic [DATA_W-1:0] i_MemRData,
    input  logic              i_MemAck,
    output logic              o_MemErr
);

    // Counter must hold TIMEOUT itself; keep at least one bit when disabled.
    localparam int unsigned     CNT_W  = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);
    localparam bit               TO_EN  = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] mar_q,   mar_d;
    logic [DATA_W-1:0] mdr_q,   mdr_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q,    we_d;
    logic [DATA_W-1:0] rdbuf_q, rdbuf_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              err_q,   err_d;

    logic [CNT_W-1:0]  cnt_inc;
    logic              timeout_hit;

    // Timeout detection: fires on the BUSY cycle whose increment reaches TIMEOUT.
    always_comb begin
        cnt_inc     = cnt_q + CNT_W'(1);
        timeout_hit = TO_EN && (cnt_inc == TO_VAL);
    end

    // State register.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; an ack in the timeout cycle still counts as success.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (i_MioEn) state_d = ST_BUSY;
            ST_BUSY: if (i_MemAck || timeout_hit) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs, decoded from the state register only.
    always_comb begin
        o_MemReq = (state_q == ST_BUSY);
        o_Ready  = (state_q == ST_DONE);
    end

    // Datapath next values: MAR/MDR loads, request latching, read buffer, counter.
    always_comb begin
        mar_d   = mar_q;
        mdr_d   = mdr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        rdbuf_d = rdbuf_q;
        cnt_d   = cnt_q;
        err_d   = err_q;

        if (i_LdMar) begin
            mar_d = ADDR_W'(i_Bus);
        end

        if (i_LdMdr) begin
            if (!i_MioEn) begin
                mdr_d = i_Bus;
            end else if (state_q == ST_DONE && !we_q) begin
                mdr_d = rdbuf_q;
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                if (i_MioEn) begin
                    // Registered MAR/MDR are used, so same-cycle loads miss this access.
                    addr_d  = mar_q;
                    wdata_d = mdr_q;
                    we_d    = i_RW;
                    cnt_d   = '0;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_inc;
                if (i_MemAck) begin
                    rdbuf_d = i_MemRData;
                end else if (timeout_hit) begin
                    rdbuf_d = '0;
                    err_d   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            mar_q   <= '0;
            mdr_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdbuf_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rdbuf_q <= rdbuf_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Register-to-port mapping.
    always_comb begin
        o_Mar      = mar_q;
        o_Mdr      = mdr_q;
        o_MemAddr  = addr_q;
        o_MemWData = wdata_q;
        o_MemWe    = we_q;
        o_MemErr   = err_q;
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a scoreboard of expected access results.
module tb_mem_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_mar, ld_mdr, mio_en, rw;
    logic [15:0] bus;
    logic [15:0] mar, mdr;
    logic        ready, mem_req, mem_we, mem_err;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [15:0] wdata;
        logic [15:0] mdr;
        logic        err;
    } exp_t;

    exp_t sb[$];

    mem_ctrl #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(TO)) dut (
        .i_Clk      (clk),
        .i_Reset    (rst),
        .i_LdMar    (ld_mar),
        .i_LdMdr    (ld_mdr),
        .i_MioEn    (mio_en),
        .i_RW       (rw),
        .i_Bus      (bus),
        .o_Mar      (mar),
        .o_Mdr      (mdr),
        .o_Ready    (ready),
        .o_MemReq   (mem_req),
        .o_MemWe    (mem_we),
        .o_MemAddr  (mem_addr),
        .o_MemWData (mem_wdata),
        .i_MemRData (mem_rdata),
        .i_MemAck   (mem_ack),
        .o_MemErr   (mem_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one access from IDLE; cycle 0 is the cycle MioEn is first sampled.
    task automatic access(input logic a_rw, input logic a_ldmdr, input int ack_cyc,
                          input logic [15:0] rdata, input logic [15:0] exp_mdr,
                          input logic exp_err, input logic pulse_mar);
        int   cyc;
        int   exp_rdy;
        exp_t e;
        e.addr  = mar;
        e.we    = a_rw;
        e.wdata = mdr;
        e.mdr   = exp_mdr;
        e.err   = exp_err;
        sb.push_back(e);
        exp_rdy = (ack_cyc == 0) ? TO + 1 : ack_cyc + 1;
        mio_en = 1'b1; rw = a_rw; ld_mdr = a_ldmdr;
        tick();
        cyc = 1;
        while (!ready && cyc < 20) begin
            chk("req_high", mem_req, 1'b1);
            chk("req_addr", mem_addr, sb[0].addr);
            chk("req_we", mem_we, sb[0].we);
            if (a_rw) chk("req_wdata", mem_wdata, sb[0].wdata);
            if (cyc == ack_cyc) begin mem_ack = 1'b1; mem_rdata = rdata; end
            if (pulse_mar && cyc == 2) begin ld_mar = 1'b1; bus = 16'hFFFF; end
            tick();
            cyc++;
            mem_ack = 1'b0; ld_mar = 1'b0; mem_rdata = 16'hDEAD;
        end
        chk("ready_seen", ready, 1'b1);
        chk("ready_cycle", cyc, exp_rdy);
        chk("req_dropped", mem_req, 1'b0);
        e = sb.pop_front();
        chk("err_at_ready", mem_err, e.err);
        tick();
        mio_en = 1'b0; rw = 1'b0; ld_mdr = 1'b0;
        chk("ready_pulse_end", ready, 1'b0);
        chk("mdr_after", mdr, e.mdr);
    endtask

    initial begin
        exp_t e;
        rst = 1'b1; ld_mar = 0; ld_mdr = 0; mio_en = 0; rw = 0;
        bus = '0; mem_rdata = '0; mem_ack = 0;
        #12;
        chk("rst_mar", mar, 16'h0);
        chk("rst_mdr", mdr, 16'h0);
        chk("rst_req", mem_req, 1'b0);
        chk("rst_ready", ready, 1'b0);
        chk("rst_err", mem_err, 1'b0);
        chk("rst_addr", mem_addr, 16'h0);
        rst = 1'b0;
        tick();

        // Read, zero wait.
        ld_mar = 1; bus = 16'h3000; tick(); ld_mar = 0;
        chk("mar_load", mar, 16'h3000);
        access(1'b0, 1'b1, 1, 16'hBEEF, 16'hBEEF, 1'b0, 1'b0);

        // Write, three waits; ack lands exactly on the timeout cycle and wins.
        ld_mar = 1; bus = 16'h4001; ld_mdr = 1; mio_en = 0; tick();
        ld_mar = 0; bus = 16'h1234; tick(); ld_mdr = 0;
        chk("mdr_bus_load", mdr, 16'h1234);
        chk("mar_4001", mar, 16'h4001);
        access(1'b1, 1'b0, 4, 16'h7777, 16'h1234, 1'b0, 1'b0);

        // Address stability while MAR is reloaded mid-request.
        ld_mar = 1; bus = 16'h3000; tick(); ld_mar = 0;
        access(1'b0, 1'b1, 3, 16'h5A5A, 16'h5A5A, 1'b0, 1'b1);
        chk("mar_reloaded", mar, 16'hFFFF);

        // Timeout on a read: MDR forced to zero, error raised.
        access(1'b0, 1'b1, 0, 16'h0000, 16'h0000, 1'b1, 1'b0);
        chk("err_sticky", mem_err, 1'b1);

        // Back-to-back reads with MioEn held high.
        e.addr = 16'hFFFF; e.we = 0; e.wdata = 0; e.err = 1;
        e.mdr = 16'h0001; sb.push_back(e);
        e.mdr = 16'h0002; sb.push_back(e);
        mio_en = 1; rw = 0; ld_mdr = 1;
        tick();                                   // cycle 1
        chk("b2b_req1", mem_req, 1'b1);
        mem_ack = 1; mem_rdata = 16'h0001; tick(); mem_ack = 0;   // cycle 2
        chk("b2b_ready1", ready, 1'b1);
        e = sb.pop_front();
        chk("b2b_err1", mem_err, e.err);
        tick();                                   // cycle 3: IDLE, restarts
        chk("b2b_mdr1", mdr, e.mdr);
        chk("b2b_idle_ready", ready, 1'b0);
        tick();                                   // cycle 4: BUSY
        chk("b2b_req2", mem_req, 1'b1);
        mem_ack = 1; mem_rdata = 16'h0002; tick(); mem_ack = 0;   // cycle 5
        chk("b2b_ready2", ready, 1'b1);
        e = sb.pop_front();
        tick();
        mio_en = 0; ld_mdr = 0;
        chk("b2b_mdr2", mdr, e.mdr);
        chk("b2b_err2", mem_err, e.err);

        // Reset in the middle of a request.
        mio_en = 1; rw = 0; ld_mdr = 1;
        tick();
        chk("mid_req", mem_req, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_req", mem_req, 1'b0);
        chk("mid_rst_mar", mar, 16'h0);
        chk("mid_rst_mdr", mdr, 16'h0);
        chk("mid_rst_err", mem_err, 1'b0);
        chk("mid_rst_addr", mem_addr, 16'h0);
        mio_en = 0; ld_mdr = 0;
        #2 rst = 1'b0;
        mem_ack = 1; mem_rdata = 16'hCAFE;
        tick();
        mem_ack = 0;
        chk("late_ack_ready", ready, 1'b0);
        tick();
        chk("late_ack_ready2", ready, 1'b0);
        chk("late_ack_mdr", mdr, 16'h0);
        chk("sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
